// File: rtl/rom_read_arbiter.sv
// rom_read_arbiter
//   Two-port round-robin read arbiter and burst sequencer in front of a
//   combinational-read ROM. A requester hands over a start address and a
//   burst length (minus one); the block walks the ROM address, registers each
//   returned byte and streams it back to the owning requester with per-beat
//   backpressure.
//
// Ports
//   clk, reset            clock, synchronous active-high reset
//   req_valid/req_ready   per-requester request handshake (bit i = requester i)
//   req_addr0/1           burst start address
//   req_len0/1            burst length minus one
//   rsp_valid/rsp_ready   per-requester beat handshake
//   rsp_data, rsp_last    shared beat data and end-of-burst flag
//   rom_addr, rom_data    registered ROM address, combinational ROM data
//   busy                  high while a burst is being read
module rom_read_arbiter #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        req_valid,
  input  logic [ADDR_W-1:0] req_addr0,
  input  logic [ADDR_W-1:0] req_addr1,
  input  logic [ADDR_W-1:0] req_len0,
  input  logic [ADDR_W-1:0] req_len1,
  output logic [1:0]        req_ready,
  output logic [1:0]        rsp_valid,
  input  logic [1:0]        rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_last,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_data,
  output logic              busy
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_READ = 1'b1;

  logic [0:0]        state;
  logic              owner;
  logic              last_owner;
  logic [ADDR_W-1:0] remaining;
  logic              out_valid;
  logic              out_last;
  logic              out_owner;
  logic [DATA_W-1:0] out_data;

  logic [1:0] grant;
  logic       idle;
  logic       accept;
  logic       acc_id;
  logic       advance;
  logic       drain;

  assign idle = (state == ST_IDLE);
  assign busy = (state == ST_READ);

  // Round robin: on a tie the requester that did not own the previous burst wins.
  always_comb begin
    grant = 2'b00;
    unique case (req_valid)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = last_owner ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
  end

  assign req_ready = idle ? grant : 2'b00;
  assign accept    = |req_ready;
  assign acc_id    = req_ready[1];

  // The output stage is refilled whenever it is empty or its beat is being taken.
  assign advance = busy & (~out_valid | rsp_ready[out_owner]);
  assign drain   = out_valid & rsp_ready[out_owner];

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      owner      <= 1'b0;
      last_owner <= 1'b1;
      rom_addr   <= '0;
      remaining  <= '0;
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_last   <= 1'b0;
      out_owner  <= 1'b0;
    end else begin
      // Accept only happens in IDLE and advance only in READ, so they never collide.
      if (accept) begin
        state     <= ST_READ;
        owner     <= acc_id;
        rom_addr  <= acc_id ? req_addr1 : req_addr0;
        remaining <= acc_id ? req_len1 : req_len0;
      end
      if (advance) begin
        out_data  <= rom_data;
        out_valid <= 1'b1;
        out_owner <= owner;
        out_last  <= (remaining == '0);
        rom_addr  <= rom_addr + ADDR_W'(1);
        remaining <= remaining - ADDR_W'(1);
        if (remaining == '0) begin
          state      <= ST_IDLE;
          last_owner <= owner;
        end
      end else if (drain) begin
        // Final beat leaving while IDLE (or nothing left to refill with).
        out_valid <= 1'b0;
      end
    end
  end

  for (genvar i = 0; i < 2; i++) begin : g_rsp
    assign rsp_valid[i] = out_valid & (out_owner == 1'(i));
  end

  assign rsp_data = out_data;
  assign rsp_last = out_last;

endmodule

// File: tb/tb_rom_read_arbiter.sv
module tb_rom_read_arbiter;
  localparam int AW = 5;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [1:0]    req_valid = 2'b00;
  logic [1:0]    rsp_ready = 2'b00;
  logic [AW-1:0] req_addr0 = '0, req_addr1 = '0, req_len0 = '0, req_len1 = '0;
  logic [1:0]    req_ready, rsp_valid;
  logic [DW-1:0] rsp_data, rom_data;
  logic [AW-1:0] rom_addr;
  logic          rsp_last, busy;

  int total = 0;
  int bad = 0;

  // Random-phase model state: expected beat stream {owner, last, data}.
  logic [9:0] expq[$];
  int         acc_total = 0;
  int         done = 0;
  logic       last_acc = 1'b1;
  logic       pend = 1'b0;

  assign rom_data = {3'b101, rom_addr};
  always #5 clk = ~clk;

  rom_read_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid),
    .req_addr0(req_addr0), .req_addr1(req_addr1),
    .req_len0(req_len0), .req_len1(req_len1),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_last(rsp_last), .rom_addr(rom_addr),
    .rom_data(rom_data), .busy(busy)
  );

  function automatic logic [7:0] exp_byte(input int a);
    return 8'(32'hA0 + (a % 32));
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One request, rsp_ready held high: checks latency, data, last, throughput.
  task automatic burst(input int r, input int a, input int l, input string tag);
    if (r == 0) begin req_addr0 = AW'(a); req_len0 = AW'(l); end
    else        begin req_addr1 = AW'(a); req_len1 = AW'(l); end
    req_valid = 2'(1 << r);
    rsp_ready = 2'b11;
    #1;
    chk({tag, ".ready"}, req_ready, 32'(1 << r));
    tick();
    req_valid = 2'b00;
    chk({tag, ".lat"}, rsp_valid, 0);
    chk({tag, ".busy"}, busy, 1);
    for (int k = 0; k <= l; k++) begin
      tick();
      chk({tag, ".valid"}, rsp_valid, 32'(1 << r));
      chk({tag, ".data"}, rsp_data, exp_byte(a + k));
      chk({tag, ".last"}, rsp_last, (k == l));
      chk({tag, ".busyb"}, busy, (k != l));
    end
    tick();
    chk({tag, ".drain"}, rsp_valid, 0);
  endtask

  // One cycle of the randomized phase, checked against the beat-stream model.
  task automatic rcycle(input bit quiet);
    logic       idle_m;
    logic [1:0] exp_rdy;
    logic [9:0] e;
    logic       taken;
    int         a, l;
    if (quiet) begin
      req_valid = 2'b00;
      rsp_ready = 2'b11;
    end else begin
      req_valid = 2'($urandom_range(0, 3));
      req_addr0 = AW'($urandom);
      req_addr1 = AW'($urandom);
      req_len0  = AW'(($urandom_range(0, 7) == 0) ? $urandom_range(0, 31) : $urandom_range(0, 3));
      req_len1  = AW'(($urandom_range(0, 7) == 0) ? $urandom_range(0, 31) : $urandom_range(0, 3));
      rsp_ready = {($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0)};
    end
    #1;
    // Idle once every accepted beat has been captured (delivered or on display).
    idle_m = ((done + ((rsp_valid != 0) ? 1 : 0)) == acc_total);
    chk("rnd.busy", busy, !idle_m);
    exp_rdy = 2'b00;
    if (idle_m) begin
      if (req_valid == 2'b01) exp_rdy = 2'b01;
      else if (req_valid == 2'b10) exp_rdy = 2'b10;
      else if (req_valid == 2'b11) exp_rdy = last_acc ? 2'b01 : 2'b10;
    end
    chk("rnd.ready", req_ready, exp_rdy);
    if (pend) chk("rnd.hold", (rsp_valid != 0), 1);
    if (rsp_valid != 0) begin
      if (expq.size() == 0) begin
        chk("rnd.spurious", rsp_valid, 0);
        taken = 1'b0;
      end else begin
        e = expq[0];
        chk("rnd.owner", rsp_valid, e[9] ? 2'b10 : 2'b01);
        chk("rnd.data", rsp_data, e[7:0]);
        chk("rnd.last", rsp_last, e[8]);
        taken = ((rsp_valid & rsp_ready) != 0);
        if (taken) begin
          void'(expq.pop_front());
          done++;
        end
      end
      pend = !taken;
    end else begin
      pend = 1'b0;
    end
    for (int i = 0; i < 2; i++) begin
      if (req_valid[i] && req_ready[i]) begin
        a = (i == 1) ? int'(req_addr1) : int'(req_addr0);
        l = (i == 1) ? int'(req_len1) : int'(req_len0);
        for (int k = 0; k <= l; k++) expq.push_back({1'(i), (k == l), exp_byte(a + k)});
        acc_total += l + 1;
        last_acc = 1'(i);
      end
    end
    tick();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int owners[$];

    // Reset state
    reset = 1'b1;
    tick(); tick();
    chk("rst.rsp_valid", rsp_valid, 0);
    chk("rst.busy", busy, 0);
    chk("rst.rom_addr", rom_addr, 0);
    chk("rst.req_ready", req_ready, 0);
    chk("rst.last", rsp_last, 0);
    chk("rst.data", rsp_data, 0);
    reset = 1'b0;

    burst(0, 5, 0, "single");
    burst(1, 30, 3, "wrap");

    // Simultaneous requests after reset
    reset = 1'b1; tick(); reset = 1'b0;
    req_addr0 = 5'd2; req_addr1 = 5'd9; req_len0 = 5'd1; req_len1 = 5'd1;
    req_valid = 2'b11; rsp_ready = 2'b11;
    #1;
    chk("sim.ready0", req_ready, 2'b01);
    tick();
    req_valid = 2'b10;
    #1;
    chk("sim.ready_read", req_ready, 2'b00);
    tick();
    chk("sim.v0", rsp_valid, 2'b01);
    chk("sim.d0", rsp_data, 8'hA2);
    chk("sim.l0", rsp_last, 0);
    tick();
    chk("sim.d1", rsp_data, 8'hA3);
    chk("sim.l1", rsp_last, 1);
    chk("sim.busy", busy, 0);
    chk("sim.ready1", req_ready, 2'b10);
    tick();
    req_valid = 2'b00;
    chk("sim.gap", rsp_valid, 0);
    chk("sim.busy1", busy, 1);
    tick();
    chk("sim.v1", rsp_valid, 2'b10);
    chk("sim.d2", rsp_data, 8'hA9);
    tick();
    chk("sim.d3", rsp_data, 8'hAA);
    chk("sim.l3", rsp_last, 1);
    tick();
    chk("sim.drain", rsp_valid, 0);

    // Fairness: both held, four single-beat bursts
    req_addr0 = 5'd16; req_addr1 = 5'd17; req_len0 = 5'd0; req_len1 = 5'd0;
    req_valid = 2'b11; rsp_ready = 2'b11;
    for (int c = 0; c < 40 && owners.size() < 4; c++) begin
      #1;
      if (req_ready != 2'b00) owners.push_back(int'(req_ready[1]));
      tick();
    end
    req_valid = 2'b00;
    chk("fair.count", owners.size(), 4);
    for (int i = 0; i < owners.size(); i++) chk("fair.owner", owners[i], i % 2);
    repeat (4) tick();

    // Backpressure on beat 2
    req_addr0 = 5'd0; req_len0 = 5'd2; req_valid = 2'b01; rsp_ready = 2'b11;
    tick();
    req_valid = 2'b00;
    tick();
    chk("bp.d0", rsp_data, 8'hA0);
    chk("bp.v0", rsp_valid, 2'b01);
    tick();
    rsp_ready = 2'b00;
    for (int s = 0; s < 3; s++) begin
      chk("bp.hold_d", rsp_data, 8'hA1);
      chk("bp.hold_v", rsp_valid, 2'b01);
      chk("bp.hold_l", rsp_last, 0);
      chk("bp.hold_addr", rom_addr, 2);
      tick();
    end
    chk("bp.hold_d", rsp_data, 8'hA1);
    rsp_ready = 2'b11;
    tick();
    chk("bp.d2", rsp_data, 8'hA2);
    chk("bp.l2", rsp_last, 1);
    chk("bp.v2", rsp_valid, 2'b01);
    tick();
    chk("bp.drain", rsp_valid, 0);

    // Reset mid-burst
    req_addr1 = 5'd4; req_len1 = 5'd7; req_valid = 2'b10; rsp_ready = 2'b11;
    tick();
    req_valid = 2'b00;
    tick(); tick();
    chk("mrst.beat2", rsp_data, 8'hA5);
    reset = 1'b1;
    tick();
    chk("mrst.valid", rsp_valid, 0);
    chk("mrst.busy", busy, 0);
    chk("mrst.rom_addr", rom_addr, 0);
    chk("mrst.last", rsp_last, 0);
    reset = 1'b0;
    burst(0, 12, 2, "post_rst");

    // Randomized traffic against the beat-stream model
    reset = 1'b1; tick(); reset = 1'b0;
    expq.delete();
    acc_total = 0; done = 0; last_acc = 1'b1; pend = 1'b0;
    for (int c = 0; c < 2000; c++) rcycle(1'b0);
    for (int c = 0; c < 200 && expq.size() != 0; c++) rcycle(1'b1);
    chk("rnd.drained", expq.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
